// File: rtl/fwd_hazard_pkg.sv
// Shared types for the EX-stage forwarding / load-use hazard control slice.
package fwd_hazard_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } pipe_dst_t;

    function automatic logic is_live(input pipe_dst_t e);
        return e.wr && (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Picks the forwarding source for one source register; the EX producer is younger and wins.
module fwd_match
    import fwd_hazard_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs,
    input  pipe_dst_t         i_ex,
    input  pipe_dst_t         i_mem,
    output fwd_sel_e          o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = is_live(i_ex)  && (i_ex.rd  == i_rs);
    assign w_mem_hit = is_live(i_mem) && (i_mem.rd == i_rs);

    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit)
            o_sel = FWD_MEM;
        else if (w_mem_hit)
            o_sel = FWD_WB;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destinations, registers EX operand-mux selects, and stalls on load-use.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic              flush,
    output logic [1:0]        ex_sel_a,
    output logic [1:0]        ex_sel_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    pipe_dst_t        r_ex;
    pipe_dst_t        r_mem;
    fwd_sel_e         r_sel_a;
    fwd_sel_e         r_sel_b;
    logic [CNT_W-1:0] r_cnt;

    fwd_sel_e  w_sel_a;
    fwd_sel_e  w_sel_b;
    logic      w_stall;
    logic      w_bubble;
    pipe_dst_t w_id;

    fwd_match u_match_a (.i_rs(id_rs1), .i_ex(r_ex), .i_mem(r_mem), .o_sel(w_sel_a));
    fwd_match u_match_b (.i_rs(id_rs2), .i_ex(r_ex), .i_mem(r_mem), .o_sel(w_sel_b));

    // Both rs fields are compared even if the instruction does not read them.
    assign w_stall = id_valid && !flush && r_ex.load && is_live(r_ex) &&
                     ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

    assign w_bubble = flush || w_stall || !id_valid;

    always_comb begin
        w_id      = '0;
        w_id.rd   = id_rd;
        w_id.wr   = id_reg_wr;
        w_id.load = id_mem_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
        end else begin
            r_mem <= r_ex;
            if (w_bubble) begin
                r_ex    <= '0;
                r_sel_a <= FWD_RF;
                r_sel_b <= FWD_RF;
            end else begin
                r_ex    <= w_id;
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_stall && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign ex_sel_a    = r_sel_a;
    assign ex_sel_b    = r_sel_b;
    assign stall       = w_stall;
    assign stall_count = r_cnt;

endmodule
